// File: rtl/heartbeat_gen_pkg.sv
// heartbeat_gen_pkg: shared state encoding and default timing for the heartbeat transmitter
package heartbeat_gen_pkg;
    // Board oscillator in Hz and the switch controller's fail window in seconds
    localparam int unsigned OSC       = 50_000_000;
    localparam int unsigned FAIL_TIME = 3;
    // Timeout is kept inside the controller's fail window so a stall is reported before it acts
    localparam int unsigned HB_HALF_PERIOD_CYC  = OSC / 2;
    localparam int unsigned HB_KICK_TIMEOUT_CYC = 2 * OSC;
    localparam int unsigned HB_START_CYC        = 10 * OSC;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_STARTUP = 2'b01,
        ST_RUN     = 2'b10,
        ST_STALLED = 2'b11
    } hb_state_t;
endpackage

// File: rtl/heartbeat_gen_cycle_counter.sv
// hb_cycle_counter: cycle counter with clear, enable and a done pulse at terminal count N-1
module hb_cycle_counter #(
    parameter int               CNT_W = 32,
    parameter logic [CNT_W-1:0] N     = 2,
    parameter bit               WRAP  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);
    localparam logic [CNT_W-1:0] LAST = N - 1'b1;
    logic [CNT_W-1:0] cnt;
    assign done = en && cnt == LAST;
    // Count while enabled; at terminal either wrap to zero or hold, never run past it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= done ? (WRAP ? '0 : cnt) : cnt + 1'b1;
    end
endmodule

// File: rtl/heartbeat_gen.sv
// heartbeat_gen: kick-driven heartbeat pin and alive level for the core-switch controller
module heartbeat_gen
    import heartbeat_gen_pkg::*;
#(
    parameter int unsigned HALF_PERIOD_CYC  = HB_HALF_PERIOD_CYC,
    parameter int unsigned KICK_TIMEOUT_CYC = HB_KICK_TIMEOUT_CYC,
    parameter int unsigned START_CYC        = HB_START_CYC,
    parameter int          CNT_W            = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       kick,
    output logic       hb_toggle,
    output logic       alive,
    output logic [1:0] state,
    output logic [7:0] stall_cnt
);
    hb_state_t  state_q, state_d;
    logic       start_done, half_done, wd_done;
    logic       hb_d, alive_d;
    logic [7:0] stall_d;
    assign state = state_q;
    hb_cycle_counter #(.CNT_W(CNT_W), .N(CNT_W'(START_CYC)), .WRAP(1'b0)) u_start (
        .clk(clk),
        .rst_n(rst_n),
        .clr(!enable || state_q != ST_STARTUP),
        .en(state_q == ST_STARTUP),
        .done(start_done)
    );
    // Half-period phase is held while stalled and restarted on every entry into RUN
    hb_cycle_counter #(.CNT_W(CNT_W), .N(CNT_W'(HALF_PERIOD_CYC)), .WRAP(1'b1)) u_half (
        .clk(clk),
        .rst_n(rst_n),
        .clr(!enable || state_q == ST_IDLE || state_q == ST_STARTUP || (state_q == ST_STALLED && kick)),
        .en(state_q == ST_RUN),
        .done(half_done)
    );
    hb_cycle_counter #(.CNT_W(CNT_W), .N(CNT_W'(KICK_TIMEOUT_CYC)), .WRAP(1'b0)) u_wd (
        .clk(clk),
        .rst_n(rst_n),
        .clr(!enable || state_q != ST_RUN || kick),
        .en(state_q == ST_RUN),
        .done(wd_done)
    );
    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            hb_toggle <= 1'b0;
            alive     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state_q   <= state_d;
            hb_toggle <= hb_d;
            alive     <= alive_d;
            stall_cnt <= stall_d;
        end
    end
    // Next state; a kick always beats a same-cycle timeout
    always_comb begin
        state_d = state_q;
        if (!enable) state_d = ST_IDLE;
        else case (state_q)
            ST_IDLE:    state_d = ST_STARTUP;
            ST_STARTUP: state_d = kick ? ST_RUN : start_done ? ST_STALLED : ST_STARTUP;
            ST_RUN:     state_d = (wd_done && !kick) ? ST_STALLED : ST_RUN;
            default:    state_d = kick ? ST_RUN : ST_STALLED;
        endcase
    end
    // Next output values; the pin only moves at half-period terminal count in RUN
    always_comb begin
        alive_d = state_d == ST_RUN;
        hb_d    = enable && (hb_toggle ^ half_done);
        stall_d = stall_cnt + 8'(state_d == ST_STALLED && state_q != ST_STALLED && stall_cnt != 8'hFF);
    end
endmodule

// File: tb/tb_heartbeat_gen.sv
// tb_heartbeat_gen: scoreboard bench for heartbeat_gen against a cycle-level reference model
module tb_heartbeat_gen;
    localparam int H = 4;
    localparam int T = 20;
    localparam int S = 10;
    typedef struct {
        logic [1:0] st;
        logic       hb;
        logic       al;
        logic [7:0] sc;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n, enable, kick, hb_toggle, alive;
    logic [1:0] state;
    logic [7:0] stall_cnt;
    int errors = 0;
    int checks = 0;
    int ms, mhb, msc, mstart, mhalf, mwd;
    exp_t sb[$];
    logic frozen;
    heartbeat_gen #(.HALF_PERIOD_CYC(H), .KICK_TIMEOUT_CYC(T), .START_CYC(S), .CNT_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .kick(kick),
        .hb_toggle(hb_toggle),
        .alive(alive),
        .state(state),
        .stall_cnt(stall_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        ms = 0; mhb = 0; msc = 0; mstart = 0; mhalf = 0; mwd = 0;
    endtask
    task automatic bump();
        if (msc < 255) msc++;
    endtask
    task automatic step(input logic en, input logic k);
        exp_t e;
        enable = en;
        kick = k;
        if (!en) begin
            ms = 0; mhb = 0; mstart = 0; mhalf = 0; mwd = 0;
        end else if (ms == 0) begin
            ms = 1; mstart = 0;
        end else if (ms == 1) begin
            if (k) begin ms = 2; mhalf = 0; mwd = 0; end
            else if (mstart == S - 1) begin ms = 3; bump(); end
            else mstart++;
        end else if (ms == 2) begin
            if (mhalf == H - 1) begin mhb ^= 1; mhalf = 0; end
            else mhalf++;
            if (k) mwd = 0;
            else if (mwd == T - 1) begin ms = 3; bump(); end
            else mwd++;
        end else if (k) begin
            ms = 2; mhalf = 0; mwd = 0;
        end
        e.st = 2'(ms);
        e.hb = mhb[0];
        e.al = ms == 2;
        e.sc = 8'(msc);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("hb_toggle", 32'(hb_toggle), 32'(e.hb));
        chk("alive", 32'(alive), 32'(e.al));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
    endtask
    initial begin
        rst_n = 1'b0; enable = 1'b0; kick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_hb", 32'(hb_toggle), 0);
        chk("rst_alive", 32'(alive), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        #2 rst_n = 1'b1;
        // No kicks after enable: startup times out into STALLED
        repeat (S + 1) step(1'b1, 1'b0);
        chk("s1_state", 32'(state), 3);
        chk("s1_stall", 32'(stall_cnt), 1);
        // Kick at STARTUP cycle 3, then every 15 cycles
        step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("s2_alive", 32'(alive), 1);
        for (int i = 1; i <= 195; i++) step(1'b1, i % 15 == 0);
        chk("s2_state", 32'(state), 2);
        // Stop kicking: stall exactly 20 cycles after the last kick
        repeat (T - 1) step(1'b1, 1'b0);
        chk("s3_pre", 32'(state), 2);
        step(1'b1, 1'b0);
        chk("s3_state", 32'(state), 3);
        chk("s3_alive", 32'(alive), 0);
        chk("s3_stall", 32'(stall_cnt), 2);
        frozen = hb_toggle;
        repeat (5) step(1'b1, 1'b0);
        chk("s3_frozen", 32'(hb_toggle), 32'(frozen));
        // Recover from STALLED, first toggle 4 cycles later from the frozen level
        step(1'b1, 1'b1);
        chk("s4_alive", 32'(alive), 1);
        repeat (H - 1) step(1'b1, 1'b0);
        chk("s4_hold", 32'(hb_toggle), 32'(frozen));
        step(1'b1, 1'b0);
        chk("s4_toggle", 32'(hb_toggle), 32'(!frozen));
        // Kick landing exactly on the watchdog terminal cycle
        step(1'b1, 1'b1);
        repeat (T - 1) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("s4_term_state", 32'(state), 2);
        chk("s4_term_stall", 32'(stall_cnt), 2);
        // Saturate stall_cnt, then disable mid-RUN
        repeat (260) begin
            repeat (T) step(1'b1, 1'b0);
            step(1'b1, 1'b1);
        end
        chk("s5_sat", 32'(stall_cnt), 255);
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("s5_state", 32'(state), 0);
        chk("s5_hb", 32'(hb_toggle), 0);
        chk("s5_alive", 32'(alive), 0);
        chk("s5_stall", 32'(stall_cnt), 255);
        // Asynchronous reset between clock edges mid-RUN
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, i == 3);
        chk("s6_run", 32'(state), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_rst_state", 32'(state), 0);
        chk("s6_rst_hb", 32'(hb_toggle), 0);
        chk("s6_rst_alive", 32'(alive), 0);
        chk("s6_rst_stall", 32'(stall_cnt), 0);
        model_reset();
        #2 rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk("s6_startup", 32'(state), 1);
        chk("s6_stall", 32'(stall_cnt), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
